// File: rtl/traffic_light_fsm_pkg.sv
// Shared types for the intersection controller: phase encoding and lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    WALK      = 3'd6,
    FLASH     = 3'd7
  } phase_e;

  // Lamp vectors are {red, yellow, green}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Control/status bundle between the intersection controller and its environment.
interface traffic_light_fsm_if;

  logic              timer_clk;
  logic              enable;
  logic              ped_req;
  logic [2:0]        ns_light;
  logic [2:0]        ew_light;
  logic              ped_walk;
  logic              ped_pending;
  traffic_pkg::phase_e phase;

  modport master (
    output timer_clk, enable, ped_req,
    input  ns_light, ew_light, ped_walk, ped_pending, phase
  );

  modport slave (
    input  timer_clk, enable, ped_req,
    output ns_light, ew_light, ped_walk, ped_pending, phase
  );

endinterface

// File: rtl/tick_edge_detect.sv
// Turns every edge of the ticker's toggle output into a one-cycle tick.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic timer_clk,
  output logic tick
);

  logic timer_q;

  // timer_q tracks the input during reset too, so releasing reset never
  // produces a tick on its own; rst is accepted only for interface symmetry.
  always_ff @(posedge clk) begin
    if (rst) timer_q <= timer_clk;
    else     timer_q <= timer_clk;
  end

  assign tick = timer_clk ^ timer_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road intersection sequencer with latched pedestrian walk and flash mode.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  traffic_light_fsm_if.slave tl
);

  logic       tick;
  phase_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       fb_q, fb_d;
  logic       pend_q, pend_d;
  logic       walk_next_q, walk_next_d;
  logic       pend_clr;

  tick_edge_detect u_tick (
    .clk       (clk),
    .rst       (rst),
    .timer_clk (tl.timer_clk),
    .tick      (tick)
  );

  function automatic logic [7:0] phase_last(phase_e p);
    case (p)
      NS_GREEN, EW_GREEN:   phase_last = 8'(GREEN_TICKS - 1);
      NS_YELLOW, EW_YELLOW: phase_last = 8'(YELLOW_TICKS - 1);
      ALL_RED_1, ALL_RED_2: phase_last = 8'(ALLRED_TICKS - 1);
      WALK:                 phase_last = 8'(WALK_TICKS - 1);
      default:              phase_last = 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALL_RED_2;
      count_q     <= 8'd0;
      fb_q        <= 1'b0;
      pend_q      <= 1'b0;
      walk_next_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      fb_q        <= fb_d;
      pend_q      <= pend_d;
      walk_next_q <= walk_next_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    fb_d        = fb_q;
    walk_next_d = walk_next_q;
    pend_clr    = 1'b0;

    if (!tl.enable) begin
      if (state_q != FLASH) begin
        state_d = FLASH;
        count_d = 8'd0;
        fb_d    = 1'b0;
      end else if (tick) begin
        fb_d = ~fb_q;
      end
    end else if (state_q == FLASH) begin
      state_d = ALL_RED_2;
      count_d = 8'd0;
      fb_d    = 1'b0;
    end else if (tick) begin
      if (count_q == phase_last(state_q)) begin
        count_d = 8'd0;
        case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALL_RED_1;
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALL_RED_2;
          ALL_RED_1: begin
            if (pend_q) begin
              state_d     = WALK;
              walk_next_d = 1'b0;
              pend_clr    = 1'b1;
            end else begin
              state_d = EW_GREEN;
            end
          end
          ALL_RED_2: begin
            if (pend_q) begin
              state_d     = WALK;
              walk_next_d = 1'b1;
              pend_clr    = 1'b1;
            end else begin
              state_d = NS_GREEN;
            end
          end
          WALK:      state_d = walk_next_q ? NS_GREEN : EW_GREEN;
          default:   state_d = ALL_RED_2;
        endcase
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  // A request arriving on the walk-entry edge survives the clear.
  assign pend_d = tl.ped_req | (pend_q & ~pend_clr);

  always_comb begin
    tl.ns_light = LAMP_R;
    tl.ew_light = LAMP_R;
    tl.ped_walk = 1'b0;
    case (state_q)
      NS_GREEN:  tl.ns_light = LAMP_G;
      NS_YELLOW: tl.ns_light = LAMP_Y;
      EW_GREEN:  tl.ew_light = LAMP_G;
      EW_YELLOW: tl.ew_light = LAMP_Y;
      WALK:      tl.ped_walk = 1'b1;
      FLASH: begin
        tl.ns_light = {1'b0, fb_q, 1'b0};
        tl.ew_light = {1'b0, fb_q, 1'b0};
      end
      default: ;
    endcase
  end

  assign tl.ped_pending = pend_q;
  assign tl.phase       = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomized bench for traffic_light_fsm against a ticks-remaining phase model.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int W  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_light_fsm_if tif();

  traffic_light_fsm #(
    .GREEN_TICKS  (G),
    .YELLOW_TICKS (Y),
    .ALLRED_TICKS (AR),
    .WALK_TICKS   (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tl  (tif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model: phase name, ticks still to serve, flash bit, pending, green after walk
  phase_e m_phase;
  phase_e m_after;
  int     m_left;
  bit     m_fb, m_pend, m_prev_tc;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(phase_e p);
    case (p)
      NS_GREEN, EW_GREEN:   return G;
      NS_YELLOW, EW_YELLOW: return Y;
      ALL_RED_1, ALL_RED_2: return AR;
      WALK:                 return W;
      default:              return 1;
    endcase
  endfunction

  function automatic logic [2:0] road_lamp(phase_e p, bit fb, bit ns_road);
    if (p == FLASH) return fb ? LAMP_Y : LAMP_OFF;
    if (ns_road) begin
      if (p == NS_GREEN)  return LAMP_G;
      if (p == NS_YELLOW) return LAMP_Y;
    end else begin
      if (p == EW_GREEN)  return LAMP_G;
      if (p == EW_YELLOW) return LAMP_Y;
    end
    return LAMP_R;
  endfunction

  task automatic model_step();
    bit tk, pend_n;
    phase_e nxt;
    tk = (tif.timer_clk != m_prev_tc);
    m_prev_tc = tif.timer_clk;
    if (rst) begin
      m_phase = ALL_RED_2; m_left = dur(ALL_RED_2);
      m_fb = 0; m_pend = 0; m_after = NS_GREEN;
      return;
    end
    pend_n = m_pend | tif.ped_req;
    if (!tif.enable) begin
      if (m_phase != FLASH) begin m_phase = FLASH; m_fb = 0; end
      else if (tk) m_fb = ~m_fb;
    end else if (m_phase == FLASH) begin
      m_phase = ALL_RED_2; m_left = dur(ALL_RED_2);
    end else if (tk) begin
      m_left--;
      if (m_left == 0) begin
        case (m_phase)
          NS_GREEN:  nxt = NS_YELLOW;
          NS_YELLOW: nxt = ALL_RED_1;
          EW_GREEN:  nxt = EW_YELLOW;
          EW_YELLOW: nxt = ALL_RED_2;
          ALL_RED_1: begin nxt = m_pend ? WALK : EW_GREEN; m_after = EW_GREEN; end
          ALL_RED_2: begin nxt = m_pend ? WALK : NS_GREEN; m_after = NS_GREEN; end
          default:   nxt = m_after;
        endcase
        if (nxt == WALK) pend_n = tif.ped_req;
        m_phase = nxt;
        m_left  = dur(nxt);
      end
    end
    m_pend = pend_n;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ns_light",    int'(tif.ns_light),    int'(road_lamp(m_phase, m_fb, 1'b1)));
    chk("ew_light",    int'(tif.ew_light),    int'(road_lamp(m_phase, m_fb, 1'b0)));
    chk("ped_walk",    int'(tif.ped_walk),    int'(m_phase == WALK));
    chk("ped_pending", int'(tif.ped_pending), int'(m_pend));
    chk("phase",       int'(tif.phase),       int'(m_phase));
  endtask

  initial begin
    int gap, spacing;
    bit toggled;
    rst = 1'b1;
    tif.timer_clk = 1'b0;
    tif.enable    = 1'b1;
    tif.ped_req   = 1'b0;
    m_prev_tc = 0; m_phase = ALL_RED_2; m_left = AR; m_fb = 0; m_pend = 0; m_after = NS_GREEN;

    cycle();
    cycle();
    chk("rst_ns",    int'(tif.ns_light), 3'b100);
    chk("rst_ew",    int'(tif.ew_light), 3'b100);
    chk("rst_phase", int'(tif.phase),    5);
    rst = 1'b0;

    gap = 3; spacing = 3;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tif.ped_req = 1'b0;
      rst = 1'b0;
      if (cyc >= 300) rst = ($urandom_range(0, 399) == 0);
      if (cyc >= 600 && $urandom_range(0, 149) == 0) tif.enable = ~tif.enable;
      if (cyc >= 3800) tif.enable = 1'b1;

      toggled = 0;
      gap--;
      if (gap <= 0) begin
        tif.timer_clk = ~tif.timer_clk;
        toggled = 1;
        if (cyc < 300)                     spacing = 3;
        else if (cyc >= 2000 && cyc < 2600) spacing = 1;
        else                               spacing = $urandom_range(1, 4);
        gap = spacing;
      end

      if ($urandom_range(0, 39) == 0) tif.ped_req = 1'b1;
      // aim requests at the walk-entry edge to exercise set-over-clear
      if (toggled && m_pend && tif.enable && !rst && m_left == 1 &&
          (m_phase == ALL_RED_1 || m_phase == ALL_RED_2))
        tif.ped_req = 1'($urandom_range(0, 1));

      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
